// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
//
// Purpose: bundles the multiplexed 7-segment display lines and the recovered
// frame outputs of seg7_scan_decoder into one port.
//
// Signals:
//   an          [NUM_DIGITS-1:0]   anode enables, active-low, an[i]=0 selects i
//   seg         [6:0]              segment lines, active-low, {a,b,c,d,e,f,g}
//   frame_bcd   [4*NUM_DIGITS-1:0] last complete frame, position i in [4i+3:4i]
//   frame_valid                    one-cycle pulse when frame_bcd is updated
//   frame_err                      frame held an undecodable position
//   scan_err                       one-cycle pulse per sample with >1 anode low
//
// Modports:
//   master  drives the display lines and observes the recovered frame
//   slave   the decoder: watches the display lines, drives the frame outputs
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);

    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic [4*NUM_DIGITS-1:0] frame_bcd;
    logic                    frame_valid;
    logic                    frame_err;
    logic                    scan_err;

    modport master (
        output an,
        output seg,
        input  frame_bcd,
        input  frame_valid,
        input  frame_err,
        input  scan_err
    );

    modport slave (
        input  an,
        input  seg,
        output frame_bcd,
        output frame_valid,
        output frame_err,
        output scan_err
    );

endinterface : seg7_scan_decoder_if

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Purpose: receiving end of a time-multiplexed 7-segment display. Watches the
// anode and segment lines, waits for each position to hold a steady pattern,
// decodes it to BCD and assembles a frame once every position has been seen.
// Glitches shorter than STABLE_CYCLES samples and blanking are ignored.
//
// Parameters:
//   NUM_DIGITS     number of display positions (anode lines), 1..8
//   STABLE_CYCLES  identical consecutive samples needed for a capture, 2..255
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    seg7_scan_decoder_if.slave
//            in : an, seg
//            out: frame_bcd, frame_valid, frame_err, scan_err (all registered)
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    seg7_scan_decoder_if.slave bus
);

    localparam int         IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] CNT_MAX      = 8'hFF;
    // Counter value on the edge before the one that reaches STABLE_CYCLES.
    localparam logic [7:0] CAPTURE_PREV = 8'(STABLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Decode table: exact active-low {a..g} match only. Result is {err, bcd};
    // anything not in the table is reported as 4'hF with err set.
    // -------------------------------------------------------------------------
    function automatic logic [4:0] decode_seg(input logic [6:0] pattern);
        case (pattern)
            7'b0000001: decode_seg = {1'b0, 4'd0};
            7'b1001111: decode_seg = {1'b0, 4'd1};
            7'b0010010: decode_seg = {1'b0, 4'd2};
            7'b0000110: decode_seg = {1'b0, 4'd3};
            7'b1001100: decode_seg = {1'b0, 4'd4};
            7'b0100100: decode_seg = {1'b0, 4'd5};
            7'b0100000: decode_seg = {1'b0, 4'd6};
            7'b0001111: decode_seg = {1'b0, 4'd7};
            7'b0000000: decode_seg = {1'b0, 4'd8};
            7'b0000100: decode_seg = {1'b0, 4'd9};
            default:    decode_seg = {1'b1, 4'hF};
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0]   s_an_q;
    logic [6:0]              s_seg_q;
    logic [7:0]              cnt_q,         cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q,        seen_d;
    logic [NUM_DIGITS-1:0]   err_q,         err_d;
    logic [4*NUM_DIGITS-1:0] staging_q,     staging_d;
    logic [4*NUM_DIGITS-1:0] frame_bcd_q,   frame_bcd_d;
    logic                    frame_err_q,   frame_err_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    scan_err_q,    scan_err_d;

    // -------------------------------------------------------------------------
    // Anode qualification of the sample being registered on this edge.
    // -------------------------------------------------------------------------
    logic [3:0]       low_cnt;
    logic [IDX_W-1:0] low_idx;
    logic             sample_valid;
    logic             sample_multi;
    logic             sample_same;

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!bus.an[i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = IDX_W'(i);
            end
        end
    end

    // Exactly one anode low selects a position; all high is blanking; more
    // than one low is a scan fault.
    assign sample_valid = (low_cnt == 4'd1);
    assign sample_multi = (low_cnt >  4'd1);

    // The incoming sample matches the one registered on the previous edge,
    // i.e. s_an_q/s_seg_q will have held the same value one edge longer.
    assign sample_same  = (bus.an == s_an_q) && (bus.seg == s_seg_q);

    // -------------------------------------------------------------------------
    // Stability counter: number of consecutive identical valid samples held
    // in s_an_q/s_seg_q, saturating at 255.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (!sample_valid) begin
            cnt_d = '0;
        end else if (!sample_same) begin
            cnt_d = 8'd1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Capture fires only on the edge where the count steps up to
    // STABLE_CYCLES, never again while it stays at or above that value.
    logic       capture;
    logic [4:0] dec;
    logic       frame_done;

    assign capture    = sample_valid && sample_same && (cnt_q == CAPTURE_PREV);
    // On a capture edge the incoming seg equals s_seg_q, so the registered
    // copy is decoded.
    assign dec        = decode_seg(s_seg_q);
    assign frame_done = &seen_q;

    // -------------------------------------------------------------------------
    // Frame assembly. Completion clears seen/err, but a capture on that same
    // edge belongs to the next frame and is applied after the clear.
    // -------------------------------------------------------------------------
    always_comb begin
        seen_d    = frame_done ? '0 : seen_q;
        err_d     = frame_done ? '0 : err_q;
        staging_d = staging_q;
        if (capture) begin
            seen_d[low_idx]                    = 1'b1;
            err_d[low_idx]                     = dec[4];
            staging_d[4*int'(low_idx) +: 4]    = dec[3:0];
        end
        // The completed frame takes the staging contents from before any
        // capture on this edge.
        frame_bcd_d   = frame_done ? staging_q : frame_bcd_q;
        frame_err_d   = frame_done ? (|err_q)  : frame_err_q;
        frame_valid_d = frame_done;
        scan_err_d    = sample_multi;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_an_q        <= '0;
            s_seg_q       <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            err_q         <= '0;
            // NOTE: the staging slots are ordinary flops, not a RAM, so they
            // are cleared with everything else and a discarded partial frame
            // leaves nothing behind.
            staging_q     <= '0;
            frame_bcd_q   <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            scan_err_q    <= 1'b0;
        end else begin
            s_an_q        <= bus.an;
            s_seg_q       <= bus.seg;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            err_q         <= err_d;
            staging_q     <= staging_d;
            frame_bcd_q   <= frame_bcd_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
            scan_err_q    <= scan_err_d;
        end
    end

    assign bus.frame_bcd   = frame_bcd_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.scan_err    = scan_err_q;

endmodule : seg7_scan_decoder

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Self-checking bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
// A reference model tracks the sample history, derives the run length of
// identical one-hot samples, decodes by table lookup and predicts the frame
// outputs for every clock. Directed scenarios add absolute checks on frame
// contents, pulse counts and pulse latency.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(S)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [6:0] seg_tbl [10];

    // Reference model state
    logic [ND+6:0]   hist[$];
    logic [ND-1:0]   m_seen;
    logic [ND-1:0]   m_err;
    logic [4*ND-1:0] m_stage;
    logic [4*ND-1:0] m_bcd;
    logic            m_ferr;

    // Observations for directed checks
    int              n_pulse;
    int              n_scan;
    int              pulse_cyc;
    logic [4*ND-1:0] pulse_bcd[$];
    logic            pulse_err[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ND-1:0] sel(input int pos);
        return ~(ND'(1) << pos);
    endfunction

    function automatic logic [31:0] pb(input int i);
        return (pulse_bcd.size() > i) ? 32'(pulse_bcd[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] pe(input int i);
        return (pulse_err.size() > i) ? 32'(pulse_err[i]) : 32'hDEAD;
    endfunction

    task automatic model_clear();
        hist.delete();
        m_seen  = '0;
        m_err   = '0;
        m_stage = '0;
        m_bcd   = '0;
        m_ferr  = 1'b0;
    endtask

    task automatic clear_obs();
        n_pulse   = 0;
        n_scan    = 0;
        pulse_cyc = -1;
        pulse_bcd.delete();
        pulse_err.delete();
    endtask

    // Advance the model by one sampling edge and return expected pulses.
    task automatic model_edge(input logic [ND-1:0] a, input logic [6:0] s,
                              output logic e_fv, output logic e_scan);
        int lows;
        int pos;
        int run;
        int digit;
        bit bad;
        logic [ND+6:0] cur;
        lows = 0;
        pos  = 0;
        run  = 0;
        for (int i = 0; i < ND; i++) begin
            if (!a[i]) begin
                lows++;
                pos = i;
            end
        end
        cur = {a, s};
        hist.push_back(cur);
        if (hist.size() > S + 2) hist.delete(0);
        if (lows == 1) begin
            for (int j = hist.size() - 1; j >= 0; j--) begin
                if (hist[j] != cur) break;
                run++;
            end
        end
        e_scan = (lows > 1);
        e_fv   = 1'b0;
        if (m_seen == '1) begin
            e_fv   = 1'b1;
            m_bcd  = m_stage;
            m_ferr = (m_err != '0);
            m_seen = '0;
            m_err  = '0;
        end
        if (run == S) begin
            digit = 15;
            bad   = 1'b1;
            for (int v = 0; v < 10; v++) begin
                if (seg_tbl[v] == s) begin
                    digit = v;
                    bad   = 1'b0;
                end
            end
            m_stage[4*pos +: 4] = 4'(digit);
            m_seen[pos]         = 1'b1;
            m_err[pos]          = bad;
        end
    endtask

    task automatic step(input logic [ND-1:0] a, input logic [6:0] s);
        logic e_fv;
        logic e_scan;
        bus.an  = a;
        bus.seg = s;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(a, s, e_fv, e_scan);
        check("frame_valid", 32'(bus.frame_valid), 32'(e_fv));
        check("scan_err",    32'(bus.scan_err),    32'(e_scan));
        check("frame_bcd",   32'(bus.frame_bcd),   32'(m_bcd));
        check("frame_err",   32'(bus.frame_err),   32'(m_ferr));
        if (bus.frame_valid === 1'b1) begin
            n_pulse++;
            pulse_cyc = cyc;
            pulse_bcd.push_back(bus.frame_bcd);
            pulse_err.push_back(bus.frame_err);
        end
        if (bus.scan_err === 1'b1) n_scan++;
    endtask

    task automatic dwell(input int pos, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(sel(pos), s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('1, 7'h7F);
    endtask

    task automatic do_reset(input int n);
        bus.an  = '1;
        bus.seg = 7'h7F;
        reset   = 1'b1;
        #1;
        check("rst_bcd",   32'(bus.frame_bcd),   32'h0);
        check("rst_valid", 32'(bus.frame_valid), 32'h0);
        check("rst_err",   32'(bus.frame_err),   32'h0);
        check("rst_scan",  32'(bus.scan_err),    32'h0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check("rst_bcd_hold",   32'(bus.frame_bcd),   32'h0);
            check("rst_valid_hold", 32'(bus.frame_valid), 32'h0);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic frame_1234(input int n);
        dwell(0, seg_tbl[1], n);
        dwell(1, seg_tbl[2], n);
        dwell(2, seg_tbl[3], n);
        dwell(3, seg_tbl[4], n);
    endtask

    initial begin
        int k;
        int len;
        logic [6:0] g;
        logic [6:0] prev;
        logic [ND-1:0] a;

        seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        reset   = 1'b1;
        bus.an  = '1;
        bus.seg = 7'h7F;
        model_clear();
        clear_obs();

        // Case 1: plain scan, exact pulse latency.
        do_reset(3);
        clear_obs();
        dwell(0, seg_tbl[1], 8);
        dwell(1, seg_tbl[2], 8);
        dwell(2, seg_tbl[3], 8);
        k = cyc + 1;
        dwell(3, seg_tbl[4], 8);
        idle(4);
        check("c1_pulses",  n_pulse,   1);
        check("c1_latency", pulse_cyc, k + S);
        check("c1_bcd",     pb(0),     32'h4321);
        check("c1_err",     pe(0),     32'h0);

        // Case 2: one-cycle glitches on position 1 before its stable dwell.
        do_reset(2);
        clear_obs();
        dwell(0, seg_tbl[1], 8);
        prev = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            g = 7'($urandom);
            while (g == prev || g == seg_tbl[2]) g = 7'($urandom);
            step(sel(1), g);
            prev = g;
        end
        dwell(1, seg_tbl[2], 8);
        dwell(2, seg_tbl[3], 8);
        dwell(3, seg_tbl[4], 8);
        idle(4);
        check("c2_pulses", n_pulse, 1);
        check("c2_bcd",    pb(0),   32'h4321);
        check("c2_err",    pe(0),   32'h0);

        // Case 3: undecodable pattern on position 2, then a clean frame.
        do_reset(2);
        clear_obs();
        dwell(0, seg_tbl[1], 8);
        dwell(1, seg_tbl[2], 8);
        dwell(2, 7'b0110000, 8);
        dwell(3, seg_tbl[4], 8);
        frame_1234(8);
        idle(4);
        check("c3_pulses",  n_pulse, 2);
        check("c3_bcd_bad", pb(0),   32'h4F21);
        check("c3_err_bad", pe(0),   32'h1);
        check("c3_bcd_ok",  pb(1),   32'h4321);
        check("c3_err_ok",  pe(1),   32'h0);

        // Case 4: two cycles with two anodes low, then a clean revisit.
        do_reset(2);
        clear_obs();
        dwell(0, seg_tbl[1], 8);
        dwell(1, seg_tbl[2], 8);
        step(4'b1100, seg_tbl[3]);
        step(4'b1100, seg_tbl[3]);
        dwell(3, seg_tbl[4], 8);
        idle(2);
        check("c4_no_pulse_yet", n_pulse, 0);
        dwell(2, seg_tbl[3], 8);
        idle(4);
        check("c4_scan_err", n_scan,  2);
        check("c4_pulses",   n_pulse, 1);
        check("c4_bcd",      pb(0),   32'h4321);

        // Case 5: continuous scan of 0,0,5,9, three rounds, random dwells.
        do_reset(2);
        clear_obs();
        for (int r = 0; r < 3; r++) begin
            dwell(0, seg_tbl[0], $urandom_range(S + 4, S));
            dwell(1, seg_tbl[0], $urandom_range(S + 4, S));
            dwell(2, seg_tbl[5], $urandom_range(S + 4, S));
            dwell(3, seg_tbl[9], $urandom_range(S + 4, S));
        end
        idle(3);
        check("c5_pulses", n_pulse, 3);
        for (int i = 0; i < 3; i++) begin
            check("c5_bcd", pb(i), 32'h9500);
            check("c5_err", pe(i), 32'h0);
        end

        // Case 6: reset with two positions captured, then a fresh frame.
        do_reset(2);
        clear_obs();
        frame_1234(8);
        dwell(0, seg_tbl[7], 8);
        dwell(1, seg_tbl[8], 8);
        check("c6_bcd_before", 32'(bus.frame_bcd), 32'h4321);
        do_reset(3);
        clear_obs();
        dwell(2, seg_tbl[6], 8);
        dwell(3, seg_tbl[9], 8);
        idle(3);
        check("c6_no_stale", n_pulse, 0);
        dwell(0, seg_tbl[5], 8);
        dwell(1, seg_tbl[3], 8);
        idle(3);
        check("c6_pulses", n_pulse, 1);
        check("c6_bcd",    pb(0),   32'h9635);
        check("c6_err",    pe(0),   32'h0);

        // Case 7: random scan order, dwell lengths, blanking, bad patterns
        // and multi-anode faults, checked cycle by cycle against the model.
        do_reset(2);
        clear_obs();
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(9, 0) < 2) idle($urandom_range(3, 1));
            len = $urandom_range(10, 1);
            if ($urandom_range(9, 0) == 0) begin
                a = ND'($urandom);
                for (int j = 0; j < len; j++) step(a, 7'($urandom));
            end else if ($urandom_range(9, 0) == 0) begin
                dwell($urandom_range(ND - 1, 0), 7'($urandom), len);
            end else begin
                dwell($urandom_range(ND - 1, 0), seg_tbl[$urandom_range(9, 0)], len + S);
            end
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_seg7_scan_decoder

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment display interface: watches the time-multiplexed anode and segment lines and recovers the BCD digit shown on each position.
- Assembles a complete frame once every position has been captured.
- Used as an in-design display readback/monitor for the digital clock and as a checker in system benches.
- Only stable dwell periods are decoded; glitches and blanking are ignored.

Parameters:
NUM_DIGITS, 4, number of display positions (anode lines), 1..8
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured, 2..255

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
an  input  NUM_DIGITS  anode enables, active-low; an[i]=0 selects position i
seg  input  7  segment lines, active-low, bit order {a,b,c,d,e,f,g} = seg[6:0]
frame_bcd  output  4*NUM_DIGITS  last complete frame; position i in bits [4i+3:4i]
frame_valid  output  1  one-cycle pulse when frame_bcd is updated
frame_err  output  1  qualifies frame_valid: at least one position in the frame held an undecodable pattern
scan_err  output  1  one-cycle pulse when sampled an has more than one bit low

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-high.
- Reset values: all outputs 0; sample regs, stability counter, staging, seen mask and error mask all cleared.
- Input stage: an and seg registered every edge into s_an/s_seg. All decisions use registered values only.
- One-hot check: s_an is valid when exactly one bit is 0.
  - All ones means blanking: counter cleared, no error.
  - More than one bit low: counter cleared, scan_err pulses the next cycle, once per sample.
- Stability counter (8-bit, saturating):
  - New sample valid and equal to the previous {s_an,s_seg}: increment.
  - New sample valid but different: load 1.
  - Sample invalid: load 0.
- Capture: occurs exactly once per dwell, on the edge where the counter reaches STABLE_CYCLES. It does not repeat while the counter saturates. Capture does the following:
  - Decodes s_seg, writes the result into staging slot i (i = index of the low anode bit).
  - Sets seen[i].
  - Sets err[i] if the pattern is undecodable, otherwise clears err[i].
- Decode table (active-low, {a..g}). Exact match required; any other pattern decodes to 4'hF with err:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
- Re-capture: capturing a position already seen in the current frame overwrites its staging slot and err bit (newest wins). This is not an error.
- Frame completion:
  - The edge after seen becomes all-ones: frame_bcd <= staging, frame_err <= OR(err), frame_valid=1 for exactly one cycle.
  - On that same edge, seen and err clear.
  - A capture on that same edge starts the new frame: its seen/err bit is set, not cleared.
- frame_bcd and frame_err hold between pulses. frame_err is meaningful only with frame_valid but is held.
- Latency: last position's pattern first sampled at edge k:
  - Staging written at edge k+STABLE_CYCLES-1.
  - frame_valid high in the cycle after edge k+STABLE_CYCLES.
- Position order is irrelevant; any scan order that eventually covers all positions completes a frame.
- Reset mid-frame: partial frame discarded. frame_bcd returns to 0 and no pulse is issued.

Test Plan:
1. NUM_DIGITS=4, STABLE_CYCLES=4. Scan an=1110,1101,1011,0111 with seg=1001111,0010010,0000110,1001100, 8 cycles each -> one frame_valid pulse, frame_bcd=16'h4321, frame_err=0. The pulse must arrive on the exact cycle given by the latency rule.
2. Same scan, but position 1 gets 1-cycle glitch patterns of 3 cycles before the stable dwell -> no capture from the glitches; result identical to case 1.
3. Position 2 shows 0110000 -> frame_bcd=16'h4F21, frame_err=1 with the pulse. The next frame with a valid pattern -> frame_err=0.
4. an=1100 for 2 cycles mid-scan -> two scan_err pulses, no capture for that dwell. The frame completes after a clean revisit.
5. Continuous scan of 0,0,5,9 repeated 3 times -> three frame_valid pulses, each frame_bcd=16'h9500. No missed frame when the first capture of a frame coincides with the completion edge.
6. Assert reset after 2 positions are captured, then run a full scan -> outputs 0 during reset, exactly one pulse afterwards, with no stale positions.
